// File: rtl/spi_ram_arbiter.sv
// spi_ram_arbiter: two-requester round-robin arbiter and sequencer that turns
// whole-word read/write transactions into the SPI data memory's two-beat
// command protocol on ram_din[9:8] and returns one response per transaction.
// Optional feature macro: SPI_RAM_ARB_TIMEOUT_EN (bounded wait for read data).
// Handshake: a request is accepted in the cycle where reqN_valid && reqN_ready;
// reqN_ready is combinational and only ever high in IDLE. Responses are
// one-cycle strobes with no backpressure.
module spi_ram_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic                  req0_wr,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic                  req1_wr,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  output logic                  rsp_valid,
  output logic                  rsp_id,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH+1:0] ram_din,
  output logic                  ram_rx_valid,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  input  logic                  ram_tx_valid,
  output logic                  busy
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ADDR    = 3'd1;
  localparam logic [2:0] S_DATA    = 3'd2;
  localparam logic [2:0] S_WAIT_RD = 3'd3;
  localparam logic [2:0] S_RESP    = 3'd4;

  logic [2:0]            state;
  logic                  rr_ptr;     // requester favoured on a tie
  logic                  grant;
  logic                  accept;
  logic                  sel_wr;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic                  lat_wr;
  logic                  lat_id;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [DATA_WIDTH-1:0] lat_wdata;

`ifdef SPI_RAM_ARB_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
  logic [7:0] wait_cnt;
`else
  logic [7:0] unused_timeout;
  assign unused_timeout = 8'(TIMEOUT);
  assign rsp_err        = 1'b0;
`endif

  // Arbitration: a lone requester wins; on a tie the round-robin pointer decides.
  always_comb begin
    if (req0_valid && !req1_valid)
      grant = 1'b0;
    else if (req1_valid && !req0_valid)
      grant = 1'b1;
    else
      grant = rr_ptr;
  end

  assign req0_ready = (state == S_IDLE) && !grant;
  assign req1_ready = (state == S_IDLE) && grant;
  assign accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);

  // Fields of the granted requester, latched on acceptance.
  always_comb begin
    sel_wr    = grant ? req1_wr    : req0_wr;
    sel_addr  = grant ? req1_addr  : req0_addr;
    sel_wdata = grant ? req1_wdata : req0_wdata;
  end

  // Sequencer FSM with registered memory-side and response outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      rr_ptr       <= 1'b0;
      lat_wr       <= 1'b0;
      lat_id       <= 1'b0;
      lat_addr     <= '0;
      lat_wdata    <= '0;
      ram_din      <= '0;
      ram_rx_valid <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_id       <= 1'b0;
      rsp_rdata    <= '0;
      busy         <= 1'b0;
`ifdef SPI_RAM_ARB_TIMEOUT_EN
      rsp_err      <= 1'b0;
      wait_cnt     <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            lat_wr       <= sel_wr;
            lat_id       <= grant;
            lat_addr     <= sel_addr;
            lat_wdata    <= sel_wdata;
            rr_ptr       <= ~grant;
            ram_din      <= {(sel_wr ? 2'b00 : 2'b10), sel_addr};
            ram_rx_valid <= 1'b1;
            busy         <= 1'b1;
            state        <= S_ADDR;
          end
        end
        S_ADDR: begin
          ram_din <= lat_wr ? {2'b01, lat_wdata} : {2'b11, {DATA_WIDTH{1'b0}}};
          state   <= S_DATA;
        end
        S_DATA: begin
          ram_din      <= '0;
          ram_rx_valid <= 1'b0;
          if (lat_wr) begin
            rsp_valid <= 1'b1;
            rsp_id    <= lat_id;
            rsp_rdata <= '0;
`ifdef SPI_RAM_ARB_TIMEOUT_EN
            rsp_err   <= 1'b0;
`endif
            state     <= S_RESP;
          end else begin
`ifdef SPI_RAM_ARB_TIMEOUT_EN
            wait_cnt  <= '0;
`endif
            state     <= S_WAIT_RD;
          end
        end
        S_WAIT_RD: begin
          // Read data arriving on the limit cycle still yields a normal response.
          if (ram_tx_valid) begin
            rsp_valid <= 1'b1;
            rsp_id    <= lat_id;
            rsp_rdata <= ram_dout;
`ifdef SPI_RAM_ARB_TIMEOUT_EN
            rsp_err   <= 1'b0;
`endif
            state     <= S_RESP;
          end
`ifdef SPI_RAM_ARB_TIMEOUT_EN
          else if (wait_cnt == TO_LAST) begin
            rsp_valid <= 1'b1;
            rsp_id    <= lat_id;
            rsp_rdata <= '0;
            rsp_err   <= 1'b1;
            state     <= S_RESP;
          end else begin
            wait_cnt  <= wait_cnt + 8'd1;
          end
`endif
        end
        S_RESP: begin
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= S_IDLE;
        end
        default: begin
          ram_din      <= '0;
          ram_rx_valid <= 1'b0;
          rsp_valid    <= 1'b0;
          busy         <= 1'b0;
          state        <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// Testbench for spi_ram_arbiter: directed transactions with a transaction-level
// reference model (beat count since acceptance, a word memory, a tie pointer),
// checked every cycle, plus hand-computed literal expectations.
module tb_spi_ram_arbiter;

  localparam int TIMEOUT = 15;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       req0_valid, req0_ready, req0_wr;
  logic [7:0] req0_addr, req0_wdata;
  logic       req1_valid, req1_ready, req1_wr;
  logic [7:0] req1_addr, req1_wdata;
  logic       rsp_valid, rsp_id, rsp_err;
  logic [7:0] rsp_rdata;
  logic [9:0] ram_din;
  logic       ram_rx_valid;
  logic [7:0] ram_dout;
  logic       ram_tx_valid;
  logic       busy;

  spi_ram_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_wr(req0_wr),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_wr(req1_wr),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .ram_din(ram_din), .ram_rx_valid(ram_rx_valid), .ram_dout(ram_dout),
    .ram_tx_valid(ram_tx_valid), .busy(busy)
  );

  int n_vec = 0;
  int n_err = 0;
  int grants[$];

  // memory / stimulus controls
  logic [7:0] mmem [256];
  bit         mem_auto = 1'b1;
  bit         stray    = 1'b0;
  bit         rd_pend  = 1'b0;
  logic [7:0] obs_addr = 8'h00;

  // reference model: expected registered outputs for the current cycle
  int         m_beat;   // 0 idle, 1 addr beat, 2 data beat, 3 awaiting data, 4 response
  int         m_wait;
  bit         m_rr, m_wr, m_id;
  logic [7:0] m_addr, m_wdata;
  logic [9:0] e_din;
  logic       e_rxv, e_rspv, e_id, e_err, e_busy;
  logic [7:0] e_rdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_grant();
    if (req0_valid != req1_valid) return req1_valid;
    return m_rr;
  endfunction

  task automatic model_reset();
    m_beat = 0; m_wait = 0; m_rr = 1'b0;
    e_din = '0; e_rxv = 0; e_rspv = 0; e_id = 0; e_err = 0; e_busy = 0; e_rdata = '0;
  endtask

  task automatic model_respond(input logic [7:0] d, input logic err);
    e_rspv = 1; e_id = m_id; e_rdata = d; e_err = err; m_beat = 4;
  endtask

  task automatic model_step();
    bit g;
    if (rst) begin
      model_reset();
      return;
    end
    case (m_beat)
      0: begin
        g = model_grant();
        if ((!g && req0_valid) || (g && req1_valid)) begin
          m_id    = g;
          m_wr    = g ? req1_wr : req0_wr;
          m_addr  = g ? req1_addr : req0_addr;
          m_wdata = g ? req1_wdata : req0_wdata;
          m_rr    = ~g;
          m_beat  = 1;
          e_din   = {(m_wr ? 2'b00 : 2'b10), m_addr};
          e_rxv   = 1; e_busy = 1;
        end
      end
      1: begin
        e_din  = m_wr ? {2'b01, m_wdata} : {2'b11, 8'h00};
        m_beat = 2;
      end
      2: begin
        e_din = '0; e_rxv = 0;
        if (m_wr) begin
          mmem[m_addr] = m_wdata;
          model_respond(8'h00, 1'b0);
        end else begin
          m_beat = 3; m_wait = 0;
        end
      end
      3: begin
        if (ram_tx_valid) model_respond(mmem[m_addr], 1'b0);
`ifdef SPI_RAM_ARB_TIMEOUT_EN
        else if (m_wait + 1 >= TIMEOUT) model_respond(8'h00, 1'b1);
`endif
        else m_wait++;
      end
      default: begin
        e_rspv = 0; e_busy = 0; m_beat = 0;
      end
    endcase
  endtask

  // One clock cycle: drive memory side, compare, sample, advance the model.
  // Entered and left just after a falling edge.
  task automatic tick();
    bit g;
    ram_tx_valid = (rd_pend && mem_auto) || stray;
    ram_dout     = (rd_pend && mem_auto) ? mmem[obs_addr] : (stray ? 8'h5C : 8'h00);
    #1;
    chk("ram_din", ram_din, e_din);
    chk("ram_rx_valid", ram_rx_valid, e_rxv);
    chk("rsp_valid", rsp_valid, e_rspv);
    chk("rsp_id", rsp_id, e_id);
    chk("rsp_rdata", rsp_rdata, e_rdata);
    chk("rsp_err", rsp_err, e_err);
    chk("busy", busy, e_busy);
    if (m_beat != 0) begin
      chk("req0_ready_busy", req0_ready, 0);
      chk("req1_ready_busy", req1_ready, 0);
    end else begin
      g = model_grant();
      if (req0_valid) chk("req0_ready", req0_ready, !g);
      if (req1_valid) chk("req1_ready", req1_ready, g);
    end
    if (ram_rx_valid && ram_din[9:8] == 2'b10) obs_addr = ram_din[7:0];
    rd_pend = ram_rx_valid && (ram_din[9:8] == 2'b11);
    if (req0_valid && req0_ready) grants.push_back(0);
    if (req1_valid && req1_ready) grants.push_back(1);
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic set_req(input bit id, input bit wr, input logic [7:0] a, input logic [7:0] d);
    if (id) begin req1_valid = 1; req1_wr = wr; req1_addr = a; req1_wdata = d; end
    else    begin req0_valid = 1; req0_wr = wr; req0_addr = a; req0_wdata = d; end
  endtask

  // Full transaction: wait for acceptance and for the response (both bounded).
  task automatic txn(input bit id, input bit wr, input logic [7:0] a, input logic [7:0] d,
                     output logic [7:0] rdata);
    int s = grants.size();
    int n = 0;
    set_req(id, wr, a, d);
    while (grants.size() == s && n < 20) begin tick(); n++; end
    chk("txn_accept_in_time", grants.size(), s + 1);
    req0_valid = 0; req1_valid = 0;
    n = 0;
    while (!rsp_valid && n < 40) begin tick(); n++; end
    chk("txn_rsp_in_time", rsp_valid, 1);
    rdata = rsp_rdata;
    tick();
  endtask

  initial begin
    logic [7:0] rd;
    int c;
    for (int i = 0; i < 256; i++) mmem[i] = 8'h00;
    req0_valid = 1; req0_wr = 0; req0_addr = 0; req0_wdata = 0;
    req1_valid = 1; req1_wr = 0; req1_addr = 0; req1_wdata = 0;
    ram_dout = 0; ram_tx_valid = 0;
    model_reset();

    // reset values, tie pointer favours requester 0
    #1;
    chk("rst_ram_din", ram_din, 10'h000);
    chk("rst_rx_valid", ram_rx_valid, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 8'h00);
    chk("rst_busy", busy, 0);
    chk("rst_req0_ready_tie", req0_ready, 1);
    chk("rst_req1_ready_tie", req1_ready, 0);
    req0_valid = 0; req1_valid = 0;
    @(negedge clk);
    tick();
    rst = 0;
    repeat (2) tick();

    // req0 writes 0xA5 to 0x0A
    set_req(0, 1, 8'h0A, 8'hA5);
    tick();
    req0_valid = 0;
    chk("wr_addr_beat", ram_din, 10'h00A);
    tick();
    chk("wr_data_beat", ram_din, 10'h1A5);
    tick();
    chk("wr_rsp_valid", rsp_valid, 1);
    chk("wr_rsp_id", rsp_id, 0);
    chk("wr_rsp_err", rsp_err, 0);
    tick();

    // req1 reads 0x0A, memory answers 0xA5 one cycle after the 11 beat
    set_req(1, 0, 8'h0A, 8'h00);
    tick();
    req1_valid = 0;
    chk("rd_addr_beat", ram_din, 10'h20A);
    tick();
    chk("rd_data_beat", ram_din, 10'h300);
    tick();
    chk("rd_no_rsp_yet", rsp_valid, 0);
    tick();
    chk("rd_rsp_valid", rsp_valid, 1);
    chk("rd_rsp_rdata", rsp_rdata, 8'hA5);
    chk("rd_rsp_id", rsp_id, 1);
    tick();

    // both requesters held valid: grants alternate 0,1,0,1
    grants.delete();
    set_req(0, 1, 8'h20, 8'h33);
    set_req(1, 0, 8'h20, 8'h00);
    c = 0;
    while (grants.size() < 4 && c < 60) begin tick(); c++; end
    req0_valid = 0; req1_valid = 0;
    repeat (8) tick();
    chk("arb_count", grants.size(), 4);
    if (grants.size() == 4) begin
      chk("arb_g0", grants[0], 0);
      chk("arb_g1", grants[1], 1);
      chk("arb_g2", grants[2], 0);
      chk("arb_g3", grants[3], 1);
    end
    chk("arb_last_rdata", rsp_rdata, 8'h33);
    chk("arb_last_id", rsp_id, 1);

    // memory never answers a read
    mem_auto = 0;
    set_req(0, 0, 8'h40, 8'h00);
    tick();
    req0_valid = 0;
`ifdef SPI_RAM_ARB_TIMEOUT_EN
    c = 1;
    while (!rsp_valid && c < 40) begin tick(); c++; end
    chk("to_rsp_cycle", c, 18);
    chk("to_rsp_err", rsp_err, 1);
    chk("to_rsp_rdata", rsp_rdata, 8'h00);
    tick();
`else
    repeat (40) tick();
    chk("noto_busy_held", busy, 1);
    rst = 1;
    model_reset();
    tick();
    rst = 0;
    tick();
`endif
    mem_auto = 1;

    // reset pulsed during the DATA beat of a write
    set_req(0, 1, 8'h50, 8'h77);
    tick();
    req0_valid = 0;
    tick();
    chk("rstmid_data_beat", ram_din, 10'h177);
    rst = 1;
    model_reset();
    #1;
    chk("rstmid_rx_valid_drop", ram_rx_valid, 0);
    chk("rstmid_busy_drop", busy, 0);
    tick();
    rst = 0;
    repeat (4) tick();
    set_req(0, 1, 8'h50, 8'h66);
    #1;
    chk("rstmid_req0_ready", req0_ready, 1);
    tick();
    req0_valid = 0;
    repeat (2) tick();
    chk("rstmid_next_rsp", rsp_valid, 1);
    tick();

    // stray ram_tx_valid in IDLE and during a write
    txn(1, 0, 8'h50, 8'h00, rd);
    chk("stray_pre_read", rd, 8'h66);
    stray = 1;
    repeat (5) tick();
    chk("stray_idle_rdata", rsp_rdata, 8'h66);
    chk("stray_idle_rsp", rsp_valid, 0);
    set_req(0, 1, 8'h60, 8'h11);
    tick();
    req0_valid = 0;
    tick();
    chk("stray_wr_rdata_held", rsp_rdata, 8'h66);
    tick();
    chk("stray_wr_rsp", rsp_valid, 1);
    chk("stray_wr_rdata", rsp_rdata, 8'h00);
    tick();
    stray = 0;
    txn(0, 0, 8'h60, 8'h00, rd);
    chk("stray_wr_landed", rd, 8'h11);
    repeat (2) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
